// File: rtl/mandel_pkg.sv
// mandel_pkg: shared definitions for the Mandelbrot scan engine and its
// rendering variants.
//   - state_t   : engine FSM state encoding
//   - ONE, TH   : 1.0 and the escape threshold 4.0 in the default wide
//                 product format (2*N_BIT-BIT_FRAC bits, BIT_FRAC fraction)
//   - cm_wrap() : last value of the colour counter before it wraps to 0
package mandel_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_MUL_XX = 3'd2,
    ST_MUL_YY = 3'd3,
    ST_MUL_XY = 3'd4,
    ST_UPDATE = 3'd5,
    ST_WRITE  = 3'd6
  } state_t;

  localparam int DEF_N_BIT    = 16;
  localparam int DEF_BIT_FRAC = 12;
  localparam int DEF_WIDE_W   = 2 * DEF_N_BIT - DEF_BIT_FRAC;

  localparam logic signed [DEF_WIDE_W-1:0] ONE = DEF_WIDE_W'(1 << DEF_BIT_FRAC);
  localparam logic signed [DEF_WIDE_W-1:0] TH  = DEF_WIDE_W'(4 * ONE);

  // Colour indices 1..2^W-1 are used for escaped pixels (0 marks in-set),
  // so the counter runs 0..2^W-2 and wraps.
  function automatic int cm_wrap(input int color_w);
    return (1 << color_w) - 2;
  endfunction

endpackage

// File: rtl/mandel_mult.sv
// mandel_mult: combinational signed fixed-point multiplier, sign-magnitude
// style. Magnitudes are multiplied, the product is truncated by BIT_FRAC
// bits and then negated when the operand signs differ, so the result rounds
// toward zero.
//   a, b : signed N_BIT operands, BIT_FRAC fractional bits
//   p    : signed product, 2*N_BIT-BIT_FRAC bits, BIT_FRAC fractional bits
module mandel_mult #(
  parameter int N_BIT    = 16,
  parameter int BIT_FRAC = 12
) (
  input  logic signed [N_BIT-1:0]            a,
  input  logic signed [N_BIT-1:0]            b,
  output logic signed [2*N_BIT-BIT_FRAC-1:0] p
);

  localparam int WIDE_W = 2 * N_BIT - BIT_FRAC;

  logic [N_BIT-1:0]   mag_a;
  logic [N_BIT-1:0]   mag_b;
  logic [2*N_BIT-1:0] mag_p;
  logic [WIDE_W-1:0]  mag_t;
  logic               neg;

  always_comb begin
    // The most negative value maps to 2^(N_BIT-1), which still fits unsigned.
    mag_a = a[N_BIT-1] ? $unsigned(-a) : $unsigned(a);
    mag_b = b[N_BIT-1] ? $unsigned(-b) : $unsigned(b);
    neg   = a[N_BIT-1] ^ b[N_BIT-1];
    mag_p = {{N_BIT{1'b0}}, mag_a} * {{N_BIT{1'b0}}, mag_b};
    mag_t = WIDE_W'(mag_p >> BIT_FRAC);
    p     = neg ? -$signed(mag_t) : $signed(mag_t);
  end

endmodule

// File: rtl/mandel_scan_engine.sv
// mandel_scan_engine: sweeps a pixel window in raster order (X inner) and
// iterates z <- z^2 + c for each pixel with one shared multiplier (4 cycles
// per iteration), then emits one colour-index write per pixel.
//   clk, rst_n         : clock, synchronous active-low reset
//   start, abort       : frame start pulse (ignored while busy), frame abort
//   cfg_cxs, cfg_cys   : c of pixel (0,0), signed Q format
//   cfg_dcx, cfg_dcy   : per-pixel c step, signed
//   cfg_pix_x/y        : window size (0 treated as 1)
//   cfg_max_iter       : iteration limit (0 treated as 1)
//   busy, done         : frame in progress, one-cycle end-of-frame pulse
//   wr_valid, wr_ready : pixel write handshake
//   wr_x, wr_y, wr_data: pixel coordinate and colour index (0 = in set)
module mandel_scan_engine
  import mandel_pkg::*;
#(
  parameter int N_BIT    = 16,
  parameter int BIT_FRAC = 12,
  parameter int X_W      = 9,
  parameter int Y_W      = 8,
  parameter int ITER_W   = 16,
  parameter int COLOR_W  = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic signed [N_BIT-1:0] cfg_cxs,
  input  logic signed [N_BIT-1:0] cfg_cys,
  input  logic signed [N_BIT-1:0] cfg_dcx,
  input  logic signed [N_BIT-1:0] cfg_dcy,
  input  logic [X_W-1:0]          cfg_pix_x,
  input  logic [Y_W-1:0]          cfg_pix_y,
  input  logic [ITER_W-1:0]       cfg_max_iter,
  output logic                    busy,
  output logic                    done,
  output logic                    wr_valid,
  input  logic                    wr_ready,
  output logic [X_W-1:0]          wr_x,
  output logic [Y_W-1:0]          wr_y,
  output logic [COLOR_W-1:0]      wr_data
);

  localparam int WIDE_W = 2 * N_BIT - BIT_FRAC;
  localparam int SUM_W  = WIDE_W + 2;
  localparam bit DEFAULT_FMT = (N_BIT == DEF_N_BIT) && (BIT_FRAC == DEF_BIT_FRAC);
  localparam logic signed [WIDE_W-1:0] TH_W =
    DEFAULT_FMT ? WIDE_W'(TH) : WIDE_W'(4 << BIT_FRAC);
  localparam logic [COLOR_W-1:0] CM_LAST = COLOR_W'(cm_wrap(COLOR_W));

  // Truncate a wide sum back to the N_BIT working word (two's complement wrap).
  function automatic logic signed [N_BIT-1:0] wrap_n(input logic signed [SUM_W-1:0] v);
    return $signed(N_BIT'(v));
  endfunction

  state_t state, state_nx;

  // Latched frame configuration
  logic signed [N_BIT-1:0] cxs_l, cys_l, dcx_l, dcy_l;
  logic [X_W-1:0]          pix_x_l;
  logic [Y_W-1:0]          pix_y_l;
  logic [ITER_W-1:0]       max_l;

  // Per-pixel state
  logic [X_W-1:0]          px;
  logic [Y_W-1:0]          py;
  logic signed [N_BIT-1:0] cx, cy, x, y;
  logic [ITER_W-1:0]       i;
  logic [COLOR_W-1:0]      cm;
  logic [COLOR_W-1:0]      wr_data_q;
  logic                    done_q;

  // Registered wide products
  logic signed [WIDE_W-1:0] xx_p1, yy_p1, xy_p1;

  logic signed [N_BIT-1:0]  mul_a, mul_b;
  logic signed [WIDE_W-1:0] mul_p;
  logic signed [SUM_W-1:0]  s, x_sum, y_sum;
  logic [ITER_W-1:0]        i_inc;
  logic                     go, esc, lim, last_x, last_pix, accept;

  // The single multiplier is steered by state: x*x, then y*y, then x*y.
  assign mul_a = (state == ST_MUL_YY) ? y : x;
  assign mul_b = (state == ST_MUL_XX) ? x : y;

  mandel_mult #(.N_BIT(N_BIT), .BIT_FRAC(BIT_FRAC)) u_mult (
    .a(mul_a),
    .b(mul_b),
    .p(mul_p)
  );

  assign s        = SUM_W'(xx_p1) + SUM_W'(yy_p1);
  assign x_sum    = SUM_W'(xx_p1) - SUM_W'(yy_p1) + SUM_W'(cx);
  assign y_sum    = (SUM_W'(xy_p1) <<< 1) + SUM_W'(cy);
  assign esc      = (s >= SUM_W'(TH_W));
  assign i_inc    = i + ITER_W'(1);
  assign lim      = (i_inc == max_l);
  assign last_x   = (px == pix_x_l - X_W'(1));
  assign last_pix = last_x && (py == pix_y_l - Y_W'(1));
  assign accept   = (state == ST_WRITE) && wr_ready;
  // A start on the done cycle belongs to the frame just finished and is dropped.
  assign go       = start && !abort && !done_q;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:   if (go) state_nx = ST_LOAD;
      ST_LOAD:   state_nx = ST_MUL_XX;
      ST_MUL_XX: state_nx = ST_MUL_YY;
      ST_MUL_YY: state_nx = ST_MUL_XY;
      ST_MUL_XY: state_nx = ST_UPDATE;
      ST_UPDATE: state_nx = (esc || lim) ? ST_WRITE : ST_MUL_XX;
      ST_WRITE:  if (wr_ready) state_nx = last_pix ? ST_IDLE : ST_LOAD;
      default:   state_nx = ST_IDLE;
    endcase
    if (abort) state_nx = ST_IDLE;
  end

  always_comb begin
    busy     = (state != ST_IDLE);
    wr_valid = (state == ST_WRITE);
    done     = done_q;
    wr_x     = px;
    wr_y     = py;
    wr_data  = wr_data_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cxs_l <= '0; cys_l <= '0; dcx_l <= '0; dcy_l <= '0;
      pix_x_l <= '0; pix_y_l <= '0; max_l <= '0;
      px <= '0; py <= '0; cx <= '0; cy <= '0;
      x <= '0; y <= '0; i <= '0; cm <= '0;
      xx_p1 <= '0; yy_p1 <= '0; xy_p1 <= '0;
      wr_data_q <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= accept && last_pix && !abort;
      unique case (state)
        ST_IDLE: begin
          if (go) begin
            cxs_l   <= cfg_cxs;
            cys_l   <= cfg_cys;
            dcx_l   <= cfg_dcx;
            dcy_l   <= cfg_dcy;
            pix_x_l <= (cfg_pix_x == '0) ? X_W'(1) : cfg_pix_x;
            pix_y_l <= (cfg_pix_y == '0) ? Y_W'(1) : cfg_pix_y;
            max_l   <= (cfg_max_iter == '0) ? ITER_W'(1) : cfg_max_iter;
            px <= '0;
            py <= '0;
            cx <= cfg_cxs;
            cy <= cfg_cys;
          end
        end
        ST_LOAD: begin
          x  <= '0;
          y  <= '0;
          i  <= '0;
          cm <= '0;
        end
        // Multiply stages: one product registered per cycle
        ST_MUL_XX: xx_p1 <= mul_p;
        ST_MUL_YY: yy_p1 <= mul_p;
        ST_MUL_XY: xy_p1 <= mul_p;
        // Update stage: escape / limit decision or next z
        ST_UPDATE: begin
          if (esc) begin
            wr_data_q <= cm + COLOR_W'(1);
          end else if (lim) begin
            wr_data_q <= '0;
          end else begin
            x  <= wrap_n(x_sum);
            y  <= wrap_n(y_sum);
            i  <= i_inc;
            cm <= (cm == CM_LAST) ? '0 : cm + COLOR_W'(1);
          end
        end
        // Write stage: raster step once the pixel is accepted
        ST_WRITE: begin
          if (wr_ready) begin
            if (last_x) begin
              px <= '0;
              cx <= cxs_l;
              py <= py + Y_W'(1);
              cy <= cy + dcy_l;
            end else begin
              px <= px + X_W'(1);
              cx <= cx + dcx_l;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mandel_scan_engine.sv
// tb_mandel_scan_engine: directed self-checking bench for mandel_scan_engine
// in Q4.12, with hand-computed latencies, colour indices and raster order.
module tb_mandel_scan_engine;

  localparam int N_BIT    = 16;
  localparam int BIT_FRAC = 12;
  localparam int X_W      = 9;
  localparam int Y_W      = 8;
  localparam int ITER_W   = 16;
  localparam int COLOR_W  = 3;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    start = 1'b0;
  logic                    abort = 1'b0;
  logic signed [N_BIT-1:0] cfg_cxs = '0, cfg_cys = '0, cfg_dcx = '0, cfg_dcy = '0;
  logic [X_W-1:0]          cfg_pix_x = '0;
  logic [Y_W-1:0]          cfg_pix_y = '0;
  logic [ITER_W-1:0]       cfg_max_iter = '0;
  logic                    wr_ready = 1'b0;
  logic                    busy, done, wr_valid;
  logic [X_W-1:0]          wr_x;
  logic [Y_W-1:0]          wr_y;
  logic [COLOR_W-1:0]      wr_data;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  mandel_scan_engine #(
    .N_BIT(N_BIT), .BIT_FRAC(BIT_FRAC), .X_W(X_W), .Y_W(Y_W),
    .ITER_W(ITER_W), .COLOR_W(COLOR_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_cxs(cfg_cxs), .cfg_cys(cfg_cys), .cfg_dcx(cfg_dcx), .cfg_dcy(cfg_dcy),
    .cfg_pix_x(cfg_pix_x), .cfg_pix_y(cfg_pix_y), .cfg_max_iter(cfg_max_iter),
    .busy(busy), .done(done), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic [15:0] cxs, input logic [15:0] cys,
                         input logic [15:0] dcx, input logic [15:0] dcy,
                         input logic [8:0] pxs, input logic [7:0] pys,
                         input logic [15:0] mi);
    cfg_cxs = cxs; cfg_cys = cys; cfg_dcx = dcx; cfg_dcy = dcy;
    cfg_pix_x = pxs; cfg_pix_y = pys; cfg_max_iter = mi;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(output int cycles);
    cycles = 0;
    while (wr_valid !== 1'b1 && cycles < 400) begin
      tick();
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    total_cnt++;
    if ({busy, done, wr_valid, wr_x, wr_y, wr_data} !== '0)
      $display("FAIL reset_outputs: got %b want all 0", {busy, done, wr_valid, wr_x, wr_y, wr_data});
    else pass_cnt++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_escape();
    int n;
    set_cfg(16'h1000, 16'h1000, 16'h0, 16'h0, 9'd1, 8'd1, 16'd100);
    wr_ready = 1'b1;
    pulse_start();
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL escape_busy_rise: got %b want 1", busy);
    else pass_cnt++;
    wait_valid(n);
    total_cnt++;
    if (n != 13) $display("FAIL escape_latency: got %0d want 13", n);
    else pass_cnt++;
    total_cnt++;
    if ({wr_x, wr_y, wr_data} !== {9'd0, 8'd0, 3'd3})
      $display("FAIL escape_payload: got x=%0d y=%0d d=%0d want 0 0 3", wr_x, wr_y, wr_data);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({done, busy} !== 2'b10) $display("FAIL escape_done: got done=%b busy=%b want 1 0", done, busy);
    else pass_cnt++;
    // start on the done cycle must be dropped
    start = 1'b1;
    tick();
    start = 1'b0;
    total_cnt++;
    if ({done, busy} !== 2'b00) $display("FAIL start_on_done: got done=%b busy=%b want 0 0", done, busy);
    else pass_cnt++;
  endtask

  task automatic test_in_set();
    int n;
    set_cfg(16'h0, 16'h0, 16'h0, 16'h0, 9'd1, 8'd1, 16'd5);
    wr_ready = 1'b1;
    pulse_start();
    wait_valid(n);
    total_cnt++;
    if (n != 21) $display("FAIL inset_latency: got %0d want 21", n);
    else pass_cnt++;
    total_cnt++;
    if (wr_data !== 3'd0) $display("FAIL inset_data: got %0d want 0", wr_data);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (done !== 1'b1) $display("FAIL inset_done: got %b want 1", done);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_zero_cfg();
    int n;
    set_cfg(16'h0, 16'h0, 16'h0, 16'h0, 9'd0, 8'd0, 16'd0);
    wr_ready = 1'b1;
    pulse_start();
    wait_valid(n);
    total_cnt++;
    if (n != 5 || wr_data !== 3'd0)
      $display("FAIL zero_cfg_pixel: got lat=%0d d=%0d want 5 0", n, wr_data);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({done, busy} !== 2'b10) $display("FAIL zero_cfg_done: got done=%b busy=%b want 1 0", done, busy);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_raster();
    logic [X_W-1:0] ex [6] = '{9'd0, 9'd1, 9'd2, 9'd0, 9'd1, 9'd2};
    logic [Y_W-1:0] ey [6] = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1};
    int idx = 0;
    int done_cnt = 0;
    set_cfg(16'hE000, 16'hF000, 16'h0040, 16'h0040, 9'd3, 8'd2, 16'd100);
    wr_ready = 1'b1;
    pulse_start();
    for (int c = 0; c < 300; c++) begin
      if (wr_valid === 1'b1 && wr_ready) begin
        if (idx < 6) begin
          total_cnt++;
          if (wr_x !== ex[idx] || wr_y !== ey[idx])
            $display("FAIL raster_coord%0d: got (%0d,%0d) want (%0d,%0d)", idx, wr_x, wr_y, ex[idx], ey[idx]);
          else pass_cnt++;
        end
        if (idx == 0) begin
          total_cnt++;
          if (wr_data !== 3'd2) $display("FAIL raster_data0: got %0d want 2", wr_data);
          else pass_cnt++;
        end
        idx++;
      end
      if (done === 1'b1) done_cnt++;
      tick();
    end
    total_cnt++;
    if (idx != 6 || done_cnt != 1)
      $display("FAIL raster_counts: got writes=%0d dones=%0d want 6 1", idx, done_cnt);
    else pass_cnt++;
  endtask

  task automatic test_back_pressure();
    int n;
    set_cfg(16'h1000, 16'h1000, 16'h0, 16'h0, 9'd2, 8'd1, 16'd100);
    wr_ready = 1'b0;
    pulse_start();
    wait_valid(n);
    total_cnt++;
    if (n != 13) $display("FAIL bp_latency: got %0d want 13", n);
    else pass_cnt++;
    for (int k = 0; k < 10; k++) begin
      total_cnt++;
      if ({wr_valid, wr_x, wr_y, wr_data} !== {1'b1, 9'd0, 8'd0, 3'd3})
        $display("FAIL bp_hold%0d: got v=%b x=%0d y=%0d d=%0d want 1 0 0 3", k, wr_valid, wr_x, wr_y, wr_data);
      else pass_cnt++;
      tick();
    end
    wr_ready = 1'b1;
    tick();
    total_cnt++;
    if ({wr_valid, done} !== 2'b00) $display("FAIL bp_no_extra: got v=%b done=%b want 0 0", wr_valid, done);
    else pass_cnt++;
    wait_valid(n);
    total_cnt++;
    if (n != 13 || {wr_x, wr_y, wr_data} !== {9'd1, 8'd0, 3'd3})
      $display("FAIL bp_second: got lat=%0d x=%0d y=%0d d=%0d want 13 1 0 3", n, wr_x, wr_y, wr_data);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (done !== 1'b1) $display("FAIL bp_done: got %b want 1", done);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_abort();
    int n;
    int bad = 0;
    set_cfg(16'h0, 16'h0, 16'h0, 16'h0, 9'd1, 8'd1, 16'd100);
    wr_ready = 1'b1;
    pulse_start();
    repeat (10) tick();   // LOAD + 10 cycles lands in MUL_YY of iteration 2
    abort = 1'b1;
    tick();
    abort = 1'b0;
    total_cnt++;
    if ({busy, wr_valid, done} !== 3'b000)
      $display("FAIL abort_idle: got busy=%b v=%b done=%b want 0 0 0", busy, wr_valid, done);
    else pass_cnt++;
    for (int k = 0; k < 20; k++) begin
      if (done !== 1'b0 || wr_valid !== 1'b0 || busy !== 1'b0) bad++;
      tick();
    end
    total_cnt++;
    if (bad != 0) $display("FAIL abort_quiet: got %0d active cycles want 0", bad);
    else pass_cnt++;
    // start together with abort in IDLE stays idle
    set_cfg(16'h1000, 16'h1000, 16'h0, 16'h0, 9'd1, 8'd1, 16'd100);
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL start_with_abort: got busy=%b want 0", busy);
    else pass_cnt++;
    pulse_start();
    wait_valid(n);
    total_cnt++;
    if (n != 13 || wr_data !== 3'd3)
      $display("FAIL abort_restart: got lat=%0d d=%0d want 13 3", n, wr_data);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (done !== 1'b1) $display("FAIL abort_restart_done: got %b want 1", done);
    else pass_cnt++;
    tick();
    // abort coinciding with the final handshake suppresses done
    pulse_start();
    wait_valid(n);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    total_cnt++;
    if ({busy, done} !== 2'b00) $display("FAIL abort_on_accept: got busy=%b done=%b want 0 0", busy, done);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_start_ignored();
    int writes = 0;
    int data_bad = 0;
    int c = 0;
    set_cfg(16'h1000, 16'h1000, 16'h0, 16'h0, 9'd2, 8'd1, 16'd100);
    wr_ready = 1'b1;
    pulse_start();
    repeat (3) tick();
    set_cfg(16'h0, 16'h0, 16'h0, 16'h0, 9'd5, 8'd5, 16'd5);
    pulse_start();
    while (done !== 1'b1 && c < 400) begin
      if (wr_valid === 1'b1) begin
        writes++;
        if (wr_data !== 3'd3) data_bad++;
      end
      tick();
      c++;
    end
    total_cnt++;
    if (writes != 2 || data_bad != 0 || done !== 1'b1)
      $display("FAIL start_busy_ignored: got writes=%0d bad=%0d done=%b want 2 0 1", writes, data_bad, done);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_reset_mid_write();
    int n;
    set_cfg(16'h1000, 16'h1000, 16'h0, 16'h0, 9'd2, 8'd1, 16'd100);
    wr_ready = 1'b1;
    pulse_start();
    wait_valid(n);
    wr_ready = 1'b0;
    tick();
    wr_ready = 1'b1;
    tick();   // first pixel accepted
    wr_ready = 1'b0;
    wait_valid(n);
    total_cnt++;
    if ({wr_valid, wr_x, wr_data} !== {1'b1, 9'd1, 3'd3})
      $display("FAIL rst_pre_write: got v=%b x=%0d d=%0d want 1 1 3", wr_valid, wr_x, wr_data);
    else pass_cnt++;
    rst_n = 1'b0;
    tick();
    total_cnt++;
    if ({busy, done, wr_valid, wr_x, wr_y, wr_data} !== '0)
      $display("FAIL rst_mid_write: got %b want all 0", {busy, done, wr_valid, wr_x, wr_y, wr_data});
    else pass_cnt++;
    rst_n = 1'b1;
    wr_ready = 1'b1;
    repeat (3) tick();
    total_cnt++;
    if ({busy, wr_valid} !== 2'b00) $display("FAIL rst_stays_idle: got busy=%b v=%b want 0 0", busy, wr_valid);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_escape();
    test_in_set();
    test_zero_cfg();
    test_raster();
    test_back_pressure();
    test_abort();
    test_start_ignored();
    test_reset_mid_write();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", pass_cnt, total_cnt);
    $fatal(1, "watchdog");
  end

endmodule
